// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the I2C bus monitor.
//   i2c_mon_state_t : bus-tracking FSM state
//   BIT_CNT_W       : width of the bit counter output
//   BITS_PER_BYTE   : SCL rises per byte including the ACK bit
package i2c_mon_pkg;
  localparam int BIT_CNT_W     = 4;
  localparam int BITS_PER_BYTE = 9;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    IDLE      = 2'd1,
    BUSY      = 2'd2,
    FREE_WAIT = 2'd3
  } i2c_mon_state_t;
endpackage

// File: rtl/dff.sv
// Plain D flop with asynchronous active-low reset and a configurable reset value.
//   clk, resetn : clock / async reset
//   d, q        : WIDTH-bit data in / out
module dff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q <= RST_VAL;
    else         q <= d;
  end
endmodule

// File: rtl/edge_detector.sv
// Enable-qualified edge detector. The history flop only advances when
// flop_en is high, and edges are reported only in those cycles.
//   clk, resetn : clock / async reset (history flop resets to 0)
//   flop_en     : sample strobe
//   signal_in   : level to watch
//   rise, fall  : combinational edge indications, valid while flop_en=1
module edge_detector (
  input  logic clk,
  input  logic resetn,
  input  logic flop_en,
  input  logic signal_in,
  output logic rise,
  output logic fall
);
  logic prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      prev <= 1'b0;
    else if (flop_en) prev <= signal_in;
  end

  assign rise = flop_en &  signal_in & ~prev;
  assign fall = flop_en & ~signal_in &  prev;
endmodule

// File: rtl/i2c_sample_prescaler.sv
// Sample-tick generator: counts 0..prescale and strobes sample_tick on the
// terminal count.
//   clk, resetn : clock / async reset
//   monitor_en  : enable; low holds the count at 0 and suppresses ticks
//   prescale    : tick period minus one
//   sample_tick : one-cycle strobe
module i2c_sample_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      monitor_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sample_tick
);
  logic [PRESCALE_WIDTH-1:0] cnt;
  logic                      run;

  // run keeps the combinational tick low while reset is asserted and for the
  // first cycle after release. The >= guards against prescale being lowered
  // below the current count, which would otherwise wrap the full counter.
  assign sample_tick = run & monitor_en & (cnt >= prescale);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run <= 1'b0;
      cnt <= '0;
    end else begin
      run <= 1'b1;
      if (!monitor_en || !run) cnt <= '0;
      else if (sample_tick)    cnt <= '0;
      else                     cnt <= cnt + PRESCALE_WIDTH'(1);
    end
  end
endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronises SCL/SDA, samples them on a programmable tick
// and derives START / repeated START / STOP, bus busy, bit/byte framing and a
// sticky arbitration-loss flag.
//   clk, resetn        : clock / async active-low reset
//   monitor_en         : block enable
//   prescale           : tick period minus one (clk cycles)
//   bus_free_time      : ticks after STOP before bus_busy drops
//   scl_in, sda_in     : raw pad inputs
//   master_sda_release : local master is driving SDA high
//   arb_lost_clr       : clears arb_lost (a simultaneous set wins)
//   sample_tick        : sample strobe
//   start_det, rstart_det, stop_det, byte_done : one-cycle registered pulses
//   bit_cnt            : SCL rises since last (r)START, 0..8
//   bus_busy           : bus owned by some master
//   arb_lost           : sticky arbitration loss
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int FREE_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      monitor_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [FREE_CNT_WIDTH-1:0] bus_free_time,
  input  logic                      scl_in,
  input  logic                      sda_in,
  input  logic                      master_sda_release,
  input  logic                      arb_lost_clr,
  output logic                      sample_tick,
  output logic                      start_det,
  output logic                      rstart_det,
  output logic                      stop_det,
  output logic                      byte_done,
  output logic [BIT_CNT_W-1:0]      bit_cnt,
  output logic                      bus_busy,
  output logic                      arb_lost
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

  // ---- synchronisers: bit 1 = SCL, bit 0 = SDA, reset high (idle bus) ----
  logic [SYNC_STAGES:0][1:0] sync;
  assign sync[0] = {scl_in, sda_in};

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    dff #(.WIDTH(2), .RST_VAL(2'b11)) u_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (sync[g]),
      .q      (sync[g+1])
    );
  end

  logic scl_s, sda_s;
  assign scl_s = sync[SYNC_STAGES][1];
  assign sda_s = sync[SYNC_STAGES][0];

  // ---- sample tick and edge detection ----
  i2c_sample_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_presc (
    .clk         (clk),
    .resetn      (resetn),
    .monitor_en  (monitor_en),
    .prescale    (prescale),
    .sample_tick (sample_tick)
  );

  logic scl_rise, scl_fall, sda_rise, sda_fall;

  edge_detector u_scl_edge (
    .clk       (clk),
    .resetn    (resetn),
    .flop_en   (sample_tick),
    .signal_in (scl_s),
    .rise      (scl_rise),
    .fall      (scl_fall)
  );

  edge_detector u_sda_edge (
    .clk       (clk),
    .resetn    (resetn),
    .flop_en   (sample_tick),
    .signal_in (sda_s),
    .rise      (sda_rise),
    .fall      (sda_fall)
  );

  // ---- bus conditions (edges are already tick-qualified) ----
  // An SCL edge in the same tick makes SDA movement ambiguous, so no condition.
  logic scl_edge, start_cond, stop_cond, arb_set;
  assign scl_edge   = scl_rise | scl_fall;
  assign start_cond = sda_fall & scl_s & ~scl_edge;
  assign stop_cond  = sda_rise & scl_s & ~scl_edge;

  i2c_mon_state_t state;
  assign arb_set = scl_rise & (state == BUSY) & master_sda_release & ~sda_s;

  logic [FREE_CNT_WIDTH-1:0] free_cnt;
  logic [FREE_CNT_WIDTH:0]   free_inc;
  logic                      free_done;
  assign free_inc  = {1'b0, free_cnt} + {{FREE_CNT_WIDTH{1'b0}}, 1'b1};
  // >= so that bus_free_time=0 behaves like 1: leave on the first tick.
  assign free_done = free_inc >= {1'b0, bus_free_time};

  // ---- bus-tracking FSM with registered outputs ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARM;
      free_cnt   <= '0;
      bit_cnt    <= '0;
      bus_busy   <= 1'b0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      byte_done  <= 1'b0;
      if (!monitor_en) begin
        state    <= ARM;
        bit_cnt  <= '0;
        bus_busy <= 1'b0;
        free_cnt <= '0;
      end else if (sample_tick) begin
        case (state)
          // First tick after arming sees spurious rises from the 0-reset
          // detector history; drop them.
          ARM: state <= IDLE;
          IDLE: begin
            if (start_cond) begin
              state     <= BUSY;
              bus_busy  <= 1'b1;
              bit_cnt   <= '0;
              start_det <= 1'b1;
            end
          end
          BUSY: begin
            if (start_cond) begin
              rstart_det <= 1'b1;
              bit_cnt    <= '0;
            end else if (stop_cond) begin
              state    <= FREE_WAIT;
              stop_det <= 1'b1;
              bit_cnt  <= '0;
              free_cnt <= '0;
            end else if (scl_rise) begin
              if (bit_cnt == LAST_BIT) begin
                byte_done <= 1'b1;
                bit_cnt   <= '0;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
          FREE_WAIT: begin
            if (start_cond) begin
              state     <= BUSY;
              bit_cnt   <= '0;
              start_det <= 1'b1;
            end else if (free_done) begin
              state    <= IDLE;
              bus_busy <= 1'b0;
            end else begin
              free_cnt <= free_inc[FREE_CNT_WIDTH-1:0];
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

  // ---- sticky arbitration loss; survives monitor_en deassertion ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           arb_lost <= 1'b0;
    else if (arb_set)      arb_lost <= 1'b1;
    else if (arb_lost_clr) arb_lost <= 1'b0;
  end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: a bus-level reference model is
// compared against every DUT output on every clock, and directed scenarios
// pin timing, framing and arbitration behaviour with literal expectations.
module tb_i2c_bus_monitor;
  localparam int PW = 16;
  localparam int FW = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          monitor_en;
  logic [PW-1:0] prescale;
  logic [FW-1:0] bus_free_time;
  logic          scl_in, sda_in;
  logic          master_sda_release, arb_lost_clr;
  logic          sample_tick, start_det, rstart_det, stop_det, byte_done;
  logic [3:0]    bit_cnt;
  logic          bus_busy, arb_lost;

  i2c_bus_monitor #(.PRESCALE_WIDTH(PW), .SYNC_STAGES(2), .FREE_CNT_WIDTH(FW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .monitor_en         (monitor_en),
    .prescale           (prescale),
    .bus_free_time      (bus_free_time),
    .scl_in             (scl_in),
    .sda_in             (sda_in),
    .master_sda_release (master_sda_release),
    .arb_lost_clr       (arb_lost_clr),
    .sample_tick        (sample_tick),
    .start_det          (start_det),
    .rstart_det         (rstart_det),
    .stop_det           (stop_det),
    .byte_done          (byte_done),
    .bit_cnt            (bit_cnt),
    .bus_busy           (bus_busy),
    .arb_lost           (arb_lost)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Bus view: modes of the monitored bus, not tied to any encoding.
  localparam int M_ARM = 0, M_IDLE = 1, M_BUSY = 2, M_FREE = 3;
  int       m_mode, m_pcnt, m_bits, m_free;
  bit       m_alive, m_busy, m_arb;
  bit       m_start, m_rstart, m_stop, m_byte;
  bit [1:0] m_scl_pipe, m_sda_pipe;   // [1] is what the monitor sees
  bit       m_scl_seen, m_sda_seen;   // line level at the previous sample

  task model_reset;
    m_mode = M_ARM; m_pcnt = 0; m_bits = 0; m_free = 0;
    m_alive = 0; m_busy = 0; m_arb = 0;
    m_start = 0; m_rstart = 0; m_stop = 0; m_byte = 0;
    m_scl_pipe = 2'b11; m_sda_pipe = 2'b11;
    m_scl_seen = 0; m_sda_seen = 0;
  endtask

  task model_step;
    bit scl, sda, tk, scl_moved, sda_up, sda_down, scl_up, is_start, is_stop, lose;
    if (!resetn) begin
      model_reset();
      return;
    end
    scl = m_scl_pipe[1];
    sda = m_sda_pipe[1];
    tk  = m_alive && monitor_en && (m_pcnt >= int'(prescale));
    scl_up    = tk && scl && !m_scl_seen;
    scl_moved = tk && (scl != m_scl_seen);
    sda_up    = tk && sda && !m_sda_seen;
    sda_down  = tk && !sda && m_sda_seen;
    is_start  = sda_down && scl && !scl_moved;
    is_stop   = sda_up && scl && !scl_moved;
    lose      = scl_up && (m_mode == M_BUSY) && master_sda_release && !sda;

    m_start = 0; m_rstart = 0; m_stop = 0; m_byte = 0;
    if (!monitor_en) begin
      m_mode = M_ARM; m_bits = 0; m_busy = 0;
    end else if (tk) begin
      if (m_mode == M_ARM) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) begin
        if (is_start) begin m_mode = M_BUSY; m_busy = 1; m_bits = 0; m_start = 1; end
      end else if (m_mode == M_BUSY) begin
        if (is_start) begin m_rstart = 1; m_bits = 0; end
        else if (is_stop) begin m_mode = M_FREE; m_stop = 1; m_bits = 0; m_free = 0; end
        else if (scl_up) begin
          m_bits = m_bits + 1;
          if (m_bits == 9) begin m_byte = 1; m_bits = 0; end
        end
      end else begin
        if (is_start) begin m_mode = M_BUSY; m_bits = 0; m_start = 1; end
        else begin
          m_free = m_free + 1;
          if (m_free >= int'(bus_free_time)) begin m_mode = M_IDLE; m_busy = 0; end
        end
      end
    end
    if (lose) m_arb = 1;
    else if (arb_lost_clr) m_arb = 0;

    if (!monitor_en || !m_alive || tk) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    m_alive = 1;
    if (tk) begin m_scl_seen = scl; m_sda_seen = sda; end
    m_scl_pipe = {m_scl_pipe[0], scl_in};
    m_sda_pipe = {m_sda_pipe[0], sda_in};
  endtask

  // Compare process: every clock, 1 time unit after the edge.
  always begin
    logic [10:0] got, want;
    bit tk;
    @(posedge clk);
    model_step();
    #1;
    tk   = resetn && m_alive && monitor_en && (m_pcnt >= int'(prescale));
    got  = {sample_tick, start_det, rstart_det, stop_det, byte_done, bit_cnt, bus_busy, arb_lost};
    want = {tk, m_start, m_rstart, m_stop, m_byte, 4'(m_bits), m_busy, m_arb};
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL cycle_outputs t=%0t: got %b expected %b (tick,st,rst,sp,byte,bits[4],busy,arb)",
                  $time, got, want);
  end

  // ---------------- stimulus helpers ----------------
  int c_tick, c_start, c_rstart, c_stop, c_byte, max_bits, bad_byte, busy_drop;

  task automatic clr_counts;
    c_tick = 0; c_start = 0; c_rstart = 0; c_stop = 0; c_byte = 0;
    max_bits = 0; bad_byte = 0; busy_drop = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (sample_tick) c_tick++;
      if (start_det)   c_start++;
      if (rstart_det)  c_rstart++;
      if (stop_det)    c_stop++;
      if (byte_done) begin
        c_byte++;
        if (bit_cnt != 4'd0) bad_byte++;
      end
      if (int'(bit_cnt) > max_bits) max_bits = int'(bit_cnt);
      if (!bus_busy) busy_drop++;
    end
  endtask

  task automatic send_bit(input bit b);
    sda_in = b;  cyc(3);
    scl_in = 1;  cyc(3);
    scl_in = 0;  cyc(3);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [2:0] lat;
    logic [7:0] data;
    int k_stop, k_free;
    model_reset();
    resetn = 0; monitor_en = 0; prescale = '0; bus_free_time = 8'd5;
    scl_in = 1; sda_in = 1; master_sda_release = 0; arb_lost_clr = 0;
    cyc(3);
    chk("reset_outputs",
        int'({sample_tick, start_det, rstart_det, stop_det, byte_done, bit_cnt, bus_busy, arb_lost}), 0);

    // Prescaler: period 4, then 1, then disabled.
    resetn = 1; monitor_en = 1; prescale = 16'd3;
    clr_counts(); cyc(16);
    chk("ticks_presc3", c_tick, 4);
    chk("arm_no_cond", c_start + c_stop + c_rstart, 0);
    chk("arm_not_busy", int'(bus_busy), 0);
    prescale = 16'd0;
    clr_counts(); cyc(8);
    chk("ticks_presc0", c_tick, 8);
    monitor_en = 0;
    clr_counts(); cyc(8);
    chk("ticks_disabled", c_tick, 0);

    // Re-arm with tick every cycle, idle lines.
    monitor_en = 1;
    clr_counts(); cyc(4);
    chk("rearm_no_cond", c_start + c_stop, 0);
    chk("rearm_idle", int'(bus_busy), 0);

    // START: pulse exactly 2 sync + 1 register cycles after SDA falls.
    sda_in = 0;
    cyc(1); lat[2] = start_det;
    cyc(1); lat[1] = start_det;
    cyc(1); lat[0] = start_det;
    chk("start_latency", int'(lat), 3'b001);
    cyc(1);
    chk("start_one_cycle", int'(start_det), 0);
    chk("busy_after_start", int'(bus_busy), 1);

    // Byte 0xA5 plus ACK (9 SCL pulses).
    scl_in = 0; cyc(3);
    clr_counts();
    data = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    chk("bits_before_ack", int'(bit_cnt), 8);
    send_bit(1'b0);
    chk("byte_done_count", c_byte, 1);
    chk("byte_max_bits", max_bits, 8);
    chk("byte_done_bitcnt0", bad_byte, 0);

    // STOP, then bus_busy must fall 5 ticks later.
    sda_in = 0; cyc(3);
    scl_in = 1; cyc(3);
    sda_in = 1;
    k_stop = -1; k_free = -1;
    clr_counts();
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (stop_det && k_stop < 0) k_stop = i;
      if (k_stop >= 0 && !bus_busy && k_free < 0) k_free = i;
    end
    chk("stop_count", c_stop, 1);
    chk("free_delay", k_free - k_stop, 5);

    // START, 4 bits, repeated START.
    sda_in = 0; cyc(5);
    scl_in = 0; cyc(3);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    sda_in = 1; cyc(3);
    scl_in = 1; cyc(3);
    clr_counts();
    sda_in = 0; cyc(5);
    chk("rstart_count", c_rstart, 1);
    chk("rstart_no_start", c_start, 0);
    chk("rstart_bitcnt", int'(bit_cnt), 0);
    chk("rstart_busy", busy_drop, 0);

    // STOP then START inside the free window: bus never reported free.
    scl_in = 0; cyc(3);
    scl_in = 1; cyc(3);
    clr_counts();
    sda_in = 1; cyc(3);
    sda_in = 0; cyc(10);
    chk("fw_stop", c_stop, 1);
    chk("fw_start", c_start, 1);
    chk("fw_busy_held", busy_drop, 0);

    // Arbitration loss: released SDA reads low at an SCL rise.
    scl_in = 0; cyc(3);
    master_sda_release = 1; sda_in = 0; cyc(3);
    scl_in = 1; cyc(3);
    chk("arb_set", int'(arb_lost), 1);
    scl_in = 0; cyc(3);
    master_sda_release = 0; sda_in = 1; cyc(3);
    scl_in = 1; cyc(3);
    chk("arb_sticky", int'(arb_lost), 1);
    scl_in = 0; cyc(3);
    sda_in = 0; master_sda_release = 1; cyc(3);
    scl_in = 1; cyc(2);
    arb_lost_clr = 1; cyc(1);
    arb_lost_clr = 0;
    chk("arb_set_wins", int'(arb_lost), 1);
    scl_in = 0; cyc(3);
    master_sda_release = 0;
    arb_lost_clr = 1; cyc(1);
    arb_lost_clr = 0; cyc(1);
    chk("arb_cleared", int'(arb_lost), 0);

    // SCL and SDA moving in the same tick: no conditions.
    clr_counts();
    scl_in = 1; sda_in = 1; cyc(5);
    scl_in = 0; sda_in = 0; cyc(5);
    chk("same_tick_no_cond", c_start + c_rstart + c_stop, 0);
    chk("same_tick_busy", busy_drop, 0);

    // Asynchronous reset mid-byte.
    sda_in = 1; cyc(3);
    scl_in = 1; cyc(3);
    chk("pre_reset_bits", int'(bit_cnt != 4'd0), 1);
    resetn = 0;
    #1;
    chk("async_reset_outputs",
        int'({sample_tick, start_det, rstart_det, stop_det, byte_done, bit_cnt, bus_busy, arb_lost}), 0);
    cyc(2);
    resetn = 1; scl_in = 1; sda_in = 1;
    cyc(6);
    chk("post_reset_idle", int'(bus_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
